instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

- Two-wide instruction queue between the instruction fetch stage and the dual-issue decode stage of the superscalar core.
- Accepts the fetch bundle (base PC, 64-bit instruction pair, per-slot valids) and expands it into per-instruction entries carrying their own PC.
- Presents the oldest one or two instructions to decode in program order.
- Decouples fetch from decode stalls and is cleared on a pipeline flush (branch redirect).

## Interface

**Parameters**
- `DEPTH`, default 8: number of instruction entries. Must be a power of two, ≥ 4.

**Ports**
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: reset. Synchronous, active-high.
- `i_flush`  in  1: discard all entries (redirect). Synchronous.
- `i_pc`  in  32: base PC of the fetch bundle. Slot 0 PC = `i_pc`; slot 1 PC = `i_pc + 4` (mod 2^32).
- `i_instr`  in  64: slot 0 in `[31:0]`, slot 1 in `[63:32]`.
- `i_instr_vld`  in  2: per-slot valid.
- `o_ready`  out  1: queue can take a full bundle. High iff free entries ≥ 2.
- `o_dec_pc0`, `o_dec_pc1`  out  32 each: PCs of the head entry and the head+1 entry.
- `o_dec_instr`  out  64: head instruction in `[31:0]`, head+1 instruction in `[63:32]`.
- `o_dec_vld`  out  2: bit 0 = count ≥ 1; bit 1 = count ≥ 2.
- `i_dec_num`  in  2: number of instructions decode consumes this cycle (0, 1 or 2).
- `o_count`  out  $clog2(DEPTH)+1: current occupancy.

## Operation

- **Storage.** Circular buffer of `DEPTH` entries `{pc[31:0], instr[31:0]}`, with read pointer, write pointer ($clog2(DEPTH) bits, natural wrap) and a count register.
- **Enqueue.**
  - A bundle is accepted when `o_ready` = 1 and `i_instr_vld` ≠ 0.
  - Valid slots are compacted in order:
    - `11`: slot 0 is written at wptr and slot 1 at wptr+1; wptr advances by 2.
    - `01`: slot 0 only is written; wptr advances by 1.
    - `10`: slot 1 (PC = `i_pc+4`) is written at wptr; wptr advances by 1.
  - When `o_ready` = 0 the bundle is dropped. The producer must re-present it.
- **Dequeue.**
  - Effective take = min(`i_dec_num`, count); an `i_dec_num` value of 3 is treated as 0.
  - rptr advances by the effective take.
  - Decode must only consume slots whose `o_dec_vld` bit is set; over-request is clamped, never underflows.
- **Simultaneous enqueue and dequeue.**
  - `o_ready` is computed from the current registered count only; same-cycle dequeue does not raise it.
  - count_next = count + enq_n − deq_n.
- **Flush.**
  - `i_flush` = 1 sets count, rptr and wptr to 0 and ignores the same-cycle enqueue and dequeue.
  - Entry contents are left unchanged.
- **Reset.** `i_rst` has priority over `i_flush`. Pointers and count go to 0 and all storage entries to 0.
- **Output path.** `o_dec_*` are read combinationally from storage at rptr and rptr+1 (wrapping). There is no bypass from input to output.

## Timing

- Enqueue-to-visible latency is 1 cycle: a bundle accepted at edge N appears at the outputs after edge N (when the queue was empty).
- Dequeue takes effect at the edge; the next entries appear in the following cycle.
- Reset values:
  - `o_ready` = 1 and `o_count` = 0.
  - `o_dec_vld` = 00.
  - `o_dec_pc0` = `o_dec_pc1` = 0 and `o_dec_instr` = 0.
- Boundary conditions:
  - count = DEPTH−1: `o_ready` = 0, even if decode dequeues that cycle.
  - count = DEPTH: `o_ready` = 0; no enqueue; a dequeue still operates.
  - Wrap-around: both write and read of entries DEPTH−1 and 0 occur in the same cycle with no gap.
  - A flush in the same cycle as reset is subsumed by reset.
  - The cycle after a flush, the queue is empty and accepts a bundle.

## Test plan

- **Reset then single bundle.** After reset, `i_pc`=0x100, `i_instr`={0xBBBB_BBBB,0xAAAA_AAAA}, `i_instr_vld`=11, `i_dec_num`=0 for one cycle. Next cycle: `o_dec_vld`=11, `o_dec_pc0`=0x100, `o_dec_pc1`=0x104, `o_dec_instr`=0xBBBBBBBB_AAAAAAAA, `o_count`=2.
- **Compaction.** Enqueue `vld`=10 at pc 0x200 (instr 0xC), then `vld`=01 at pc 0x208 (instr 0xD). Head shows pc0=0x204 with instr 0xC and pc1=0x208 with instr 0xD; `o_count`=2.
- **Fill and backpressure** (DEPTH=8, decode stalled). After 3 full bundles, count=6 and `o_ready`=1. After the 4th, count=8 and `o_ready`=0. A 5th bundle is dropped and count stays 8. Then `i_dec_num`=2 for one cycle: count=6 and `o_ready`=1.
- **Streaming with wrap.** Enqueue 2 and dequeue 2 every cycle for 20 cycles with PCs 0x0, 0x8, …. Count stays constant at 2. Decode sees strictly increasing PCs, each +4, across the pointer wrap.
- **Over-request clamp.** With count=1, `i_dec_num`=2 and no enqueue: next cycle count=0 and `o_dec_vld`=00; no pointer corruption, and a subsequent bundle at 0x300 appears correctly at the head.
- **Flush priority.** With count=5, assert `i_flush` with a valid bundle and `i_dec_num`=2. Next cycle: count=0, `o_dec_vld`=00, `o_ready`=1; the bundle was not enqueued.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Two-wide instruction queue between fetch and dual-issue decode.
// Fetch bundles are compacted into per-instruction {pc, instr} entries; decode sees the oldest two.
module instr_fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic [31:0]                i_pc,
  input  logic [63:0]                i_instr,
  input  logic [1:0]                 i_instr_vld,
  output logic                       o_ready,
  output logic [31:0]                o_dec_pc0,
  output logic [31:0]                o_dec_pc1,
  output logic [63:0]                o_dec_instr,
  output logic [1:0]                 o_dec_vld,
  input  logic [1:0]                 i_dec_num,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_pc    [DEPTH];
  logic [31:0]   r_instr [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;

  logic          w_accept;
  logic [1:0]    w_enq_n;
  logic [1:0]    w_dec_req;
  logic [1:0]    w_deq_n;
  logic [31:0]   w_pc1;
  logic [31:0]   w_a_pc;
  logic [31:0]   w_a_instr;
  logic [AW-1:0] w_wptr1;
  logic [AW-1:0] w_rptr1;

  assign o_ready  = (r_count <= CW'(DEPTH - 2));
  assign w_accept = o_ready && (i_instr_vld != 2'b00);
  assign w_pc1    = i_pc + 32'd4;
  assign w_wptr1  = r_wptr + AW'(1);
  assign w_rptr1  = r_rptr + AW'(1);

  // A lone slot-1 instruction is compacted down into the first write position.
  assign w_a_pc    = (i_instr_vld == 2'b10) ? w_pc1          : i_pc;
  assign w_a_instr = (i_instr_vld == 2'b10) ? i_instr[63:32] : i_instr[31:0];

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_enq_n = 2'd0;
    if (w_accept) begin
      w_enq_n = (i_instr_vld == 2'b11) ? 2'd2 : 2'd1;
    end
  end

  // A request of 3 is meaningless and treated as no request; over-requests are clamped to the occupancy.
  assign w_dec_req = (i_dec_num == 2'd3) ? 2'd0 : i_dec_num;
  assign w_deq_n   = (CW'(w_dec_req) > r_count) ? r_count[1:0] : w_dec_req;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: storage is cleared on reset because the decode outputs read it directly and must show 0 after reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_pc[r_wptr]    <= w_a_pc;
        r_instr[r_wptr] <= w_a_instr;
      end
      if (w_accept && (i_instr_vld == 2'b11)) begin
        r_pc[w_wptr1]    <= w_pc1;
        r_instr[w_wptr1] <= i_instr[63:32];
      end
      r_wptr  <= r_wptr + AW'(w_enq_n);
      r_rptr  <= r_rptr + AW'(w_deq_n);
      r_count <= r_count + CW'(w_enq_n) - CW'(w_deq_n);
    end
  end

  assign o_dec_pc0   = r_pc[r_rptr];
  assign o_dec_pc1   = r_pc[w_rptr1];
  assign o_dec_instr = {r_instr[w_rptr1], r_instr[r_rptr]};
  assign o_dec_vld   = {(r_count >= CW'(2)), (r_count != '0)};
  assign o_count     = r_count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 8;
  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] pc;
  logic [63:0] instr;
  logic [1:0]  instr_vld;
  logic        ready;
  logic [31:0] dec_pc0;
  logic [31:0] dec_pc1;
  logic [63:0] dec_instr;
  logic [1:0]  dec_vld;
  logic [1:0]  dec_num;
  logic [3:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_pc        (pc),
    .i_instr     (instr),
    .i_instr_vld (instr_vld),
    .o_ready     (ready),
    .o_dec_pc0   (dec_pc0),
    .o_dec_pc1   (dec_pc1),
    .o_dec_instr (dec_instr),
    .o_dec_vld   (dec_vld),
    .i_dec_num   (dec_num),
    .o_count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] pc;
    logic [1:0]  dec;
    logic        flush;
    logic [3:0]  exp_cnt;
    logic        exp_rdy;
    logic [1:0]  exp_dvld;
    logic [31:0] exp_pc0;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  vec_t vecs[15];
  ent_t model[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] mk(input logic [31:0] p);
    return {(p + 32'd4) ^ K, p ^ K};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; instr_vld = 2'b00; dec_num = 2'd0; pc = '0; instr = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p, input logic [63:0] d, input logic [1:0] n);
    instr_vld = v; pc = p; instr = d; dec_num = n;
  endtask

  initial begin
    vecs[0]  = '{2'b11, 32'h1000, 2'd0, 1'b0, 4'd2, 1'b1, 2'b11, 32'h1000};
    vecs[1]  = '{2'b11, 32'h1008, 2'd0, 1'b0, 4'd4, 1'b1, 2'b11, 32'h1000};
    vecs[2]  = '{2'b11, 32'h1010, 2'd0, 1'b0, 4'd6, 1'b1, 2'b11, 32'h1000};
    vecs[3]  = '{2'b11, 32'h1018, 2'd0, 1'b0, 4'd8, 1'b0, 2'b11, 32'h1000};
    vecs[4]  = '{2'b11, 32'h1020, 2'd0, 1'b0, 4'd8, 1'b0, 2'b11, 32'h1000};
    vecs[5]  = '{2'b00, 32'h0000, 2'd2, 1'b0, 4'd6, 1'b1, 2'b11, 32'h1008};
    vecs[6]  = '{2'b01, 32'h2000, 2'd1, 1'b0, 4'd6, 1'b1, 2'b11, 32'h100C};
    vecs[7]  = '{2'b11, 32'h2008, 2'd0, 1'b0, 4'd8, 1'b0, 2'b11, 32'h100C};
    vecs[8]  = '{2'b11, 32'h2100, 2'd1, 1'b0, 4'd7, 1'b0, 2'b11, 32'h1010};
    vecs[9]  = '{2'b11, 32'h2200, 2'd2, 1'b0, 4'd5, 1'b1, 2'b11, 32'h1018};
    vecs[10] = '{2'b11, 32'h2300, 2'd2, 1'b1, 4'd0, 1'b1, 2'b00, 32'h0000};
    vecs[11] = '{2'b10, 32'h3000, 2'd0, 1'b0, 4'd1, 1'b1, 2'b01, 32'h3004};
    vecs[12] = '{2'b00, 32'h0000, 2'd3, 1'b0, 4'd1, 1'b1, 2'b01, 32'h3004};
    vecs[13] = '{2'b00, 32'h0000, 2'd2, 1'b0, 4'd0, 1'b1, 2'b00, 32'h0000};
    vecs[14] = '{2'b01, 32'h4000, 2'd0, 1'b0, 4'd1, 1'b1, 2'b01, 32'h4000};

    // Reset state, then a single full bundle.
    do_reset();
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_vld",   64'(dec_vld), 64'd0);
    check("rst_pc0",   64'(dec_pc0), 64'd0);
    check("rst_pc1",   64'(dec_pc1), 64'd0);
    check("rst_instr", dec_instr, 64'd0);
    drive(2'b11, 32'h100, {32'hBBBB_BBBB, 32'hAAAA_AAAA}, 2'd0);
    step();
    idle();
    check("single_vld",   64'(dec_vld), 64'd3);
    check("single_pc0",   64'(dec_pc0), 64'h100);
    check("single_pc1",   64'(dec_pc1), 64'h104);
    check("single_instr", dec_instr, 64'hBBBBBBBB_AAAAAAAA);
    check("single_count", 64'(count), 64'd2);

    // Compaction of lone slot-1 and slot-0 bundles.
    do_reset();
    drive(2'b10, 32'h200, {32'h0000_000C, 32'h0000_0EEE}, 2'd0);
    step();
    drive(2'b01, 32'h208, {32'h0000_0FFF, 32'h0000_000D}, 2'd0);
    step();
    idle();
    check("cmp_pc0",   64'(dec_pc0), 64'h204);
    check("cmp_pc1",   64'(dec_pc1), 64'h208);
    check("cmp_instr", dec_instr, {32'h0000_000D, 32'h0000_000C});
    check("cmp_count", 64'(count), 64'd2);

    // Directed vector table: fill, backpressure, full-with-dequeue, flush, clamp, dec_num=3.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].vld, vecs[i].pc, mk(vecs[i].pc), vecs[i].dec);
      flush = vecs[i].flush;
      step();
      idle();
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_ready", i), 64'(ready), 64'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_vld", i), 64'(dec_vld), 64'(vecs[i].exp_dvld));
      if (vecs[i].exp_dvld[0]) begin
        check($sformatf("vec%0d_pc0", i), 64'(dec_pc0), 64'(vecs[i].exp_pc0));
        check($sformatf("vec%0d_instr0", i), 64'(dec_instr[31:0]), 64'(vecs[i].exp_pc0 ^ K));
      end
    end

    // Streaming with wrap: two in, two out every cycle.
    do_reset();
    drive(2'b11, 32'h0, mk(32'h0), 2'd0);
    step();
    for (int i = 1; i <= 20; i++) begin
      drive(2'b11, 32'(i * 8), mk(32'(i * 8)), 2'd2);
      check($sformatf("stream%0d_pc0", i), 64'(dec_pc0), 64'((i - 1) * 8));
      check($sformatf("stream%0d_pc1", i), 64'(dec_pc1), 64'((i - 1) * 8 + 4));
      check($sformatf("stream%0d_instr", i), dec_instr, mk(32'((i - 1) * 8)));
      step();
      check($sformatf("stream%0d_count", i), 64'(count), 64'd2);
    end
    idle();

    // Over-request clamp from count 1, then a fresh bundle lands at the head.
    do_reset();
    drive(2'b01, 32'h50, mk(32'h50), 2'd0);
    step();
    drive(2'b00, 32'h0, 64'h0, 2'd2);
    step();
    idle();
    check("clamp_count", 64'(count), 64'd0);
    check("clamp_vld",   64'(dec_vld), 64'd0);
    drive(2'b11, 32'h300, mk(32'h300), 2'd0);
    step();
    idle();
    check("clamp_pc0",   64'(dec_pc0), 64'h300);
    check("clamp_pc1",   64'(dec_pc1), 64'h304);
    check("clamp_count2", 64'(count), 64'd2);

    // Reset together with flush clears storage as well as pointers.
    drive(2'b11, 32'h500, mk(32'h500), 2'd0);
    flush = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check("rstflush_count", 64'(count), 64'd0);
    check("rstflush_pc0",   64'(dec_pc0), 64'd0);
    check("rstflush_instr", dec_instr, 64'd0);

    // Random traffic against the reference model.
    do_reset();
    model.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [1:0]  v;
      logic [1:0]  n;
      logic        f;
      logic [31:0] p;
      logic [63:0] d;
      int          take;
      v = 2'($urandom_range(0, 3));
      n = 2'($urandom_range(0, 3));
      f = ($urandom_range(0, 31) == 0);
      p = {$urandom, 2'b00} ;
      d = {$urandom, $urandom};
      drive(v, p, d, n);
      flush = f;

      check("rnd_ready", 64'(ready), 64'(model.size() <= DEPTH - 2));
      check("rnd_count", 64'(count), 64'(model.size()));
      check("rnd_vld",   64'(dec_vld), 64'({model.size() >= 2, model.size() >= 1}));
      if (model.size() >= 1) begin
        check("rnd_pc0",    64'(dec_pc0), 64'(model[0].pc));
        check("rnd_instr0", 64'(dec_instr[31:0]), 64'(model[0].instr));
      end
      if (model.size() >= 2) begin
        check("rnd_pc1",    64'(dec_pc1), 64'(model[1].pc));
        check("rnd_instr1", 64'(dec_instr[63:32]), 64'(model[1].instr));
      end

      if (f) begin
        model.delete();
      end else begin
        bit acc;
        acc  = (model.size() <= DEPTH - 2) && (v != 2'b00);
        take = (n == 2'd3) ? 0 : int'(n);
        if (take > model.size()) take = model.size();
        repeat (take) void'(model.pop_front());
        if (acc && v[0]) model.push_back('{p, d[31:0]});
        if (acc && v[1]) model.push_back('{p + 32'd4, d[63:32]});
      end
      step();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
